// File: rtl/hs32_pkg.sv
// hs32_pkg: shared FSM state and bus-owner encodings for the HS32 memory arbiter.
package hs32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } own_e;

endpackage

// File: rtl/hs32_arb_timer.sv
// hs32_arb_timer: bus watchdog; expired rises in the TIMEOUT-th enabled cycle after clear.
// TIMEOUT = 0 disables expiry.
module hs32_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIM = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (enable)
            cnt_q <= cnt_q + 1'b1;
    end

    // Count holds cycles already spent in BUS, so the current cycle is the last when it hits TIMEOUT-1.
    assign expired = (TIMEOUT > 0) && enable && (cnt_q == LIM);

endmodule

// File: rtl/hs32_mem_arbiter.sv
// hs32_mem_arbiter: shares the HS32 memory bus between fetch and data ports, with a bus watchdog.
// Define HS32_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module hs32_mem_arbiter
    import hs32_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_stb,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic          i_err,
    output logic [DW-1:0] i_dtr,
    input  logic          d_stb,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_dtw,
    output logic          d_ack,
    output logic          d_err,
    output logic [DW-1:0] d_dtr,
    output logic          m_stb,
    output logic          m_rw,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_dtw,
    input  logic          m_ack,
    input  logic [DW-1:0] m_dtr,
    output logic          busy
);

    state_e        state_q;
    own_e          own_q;
    own_e          own_d;
    logic          grant_data;
    logic          expired;
    logic [DW-1:0] rd_data;
    logic          m_stb_q, m_rw_q, busy_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_dtw_q;
    logic          i_ack_q, i_err_q, d_ack_q, d_err_q;
    logic [DW-1:0] i_dtr_q, d_dtr_q;

`ifdef HS32_ARB_RR_EN
    own_e last_q;
    assign grant_data = d_stb && (!i_stb || last_q == OWN_FETCH);
`else
    assign grant_data = d_stb;
`endif

    assign own_d   = grant_data ? OWN_DATA : OWN_FETCH;
    assign rd_data = (m_ack && !m_rw_q) ? m_dtr : '0;

    hs32_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != ST_BUS),
        .enable  (state_q == ST_BUS),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            own_q    <= OWN_FETCH;
`ifdef HS32_ARB_RR_EN
            last_q   <= OWN_FETCH;
`endif
            m_stb_q  <= 1'b0;
            m_rw_q   <= 1'b0;
            m_addr_q <= '0;
            m_dtw_q  <= '0;
            busy_q   <= 1'b0;
            i_ack_q  <= 1'b0;
            i_err_q  <= 1'b0;
            i_dtr_q  <= '0;
            d_ack_q  <= 1'b0;
            d_err_q  <= 1'b0;
            d_dtr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (i_stb || d_stb) begin
                    state_q  <= ST_BUS;
                    own_q    <= own_d;
`ifdef HS32_ARB_RR_EN
                    last_q   <= own_d;
`endif
                    m_stb_q  <= 1'b1;
                    m_rw_q   <= grant_data & d_rw;
                    m_addr_q <= grant_data ? d_addr : i_addr;
                    m_dtw_q  <= grant_data ? d_dtw : '0;
                    busy_q   <= 1'b1;
                end
                ST_BUS: if (m_ack || expired) begin
                    state_q <= ST_RESP;
                    m_stb_q <= 1'b0;
                    if (own_q == OWN_DATA) begin
                        d_ack_q <= 1'b1;
                        d_err_q <= !m_ack;
                        d_dtr_q <= rd_data;
                    end else begin
                        i_ack_q <= 1'b1;
                        i_err_q <= !m_ack;
                        i_dtr_q <= rd_data;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    i_ack_q <= 1'b0;
                    d_ack_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_stb  = m_stb_q;
    assign m_rw   = m_rw_q;
    assign m_addr = m_addr_q;
    assign m_dtw  = m_dtw_q;
    assign busy   = busy_q;
    assign i_ack  = i_ack_q;
    assign i_err  = i_err_q;
    assign i_dtr  = i_dtr_q;
    assign d_ack  = d_ack_q;
    assign d_err  = d_err_q;
    assign d_dtr  = d_dtr_q;

endmodule

// File: doc/hs32_mem_arbiter.md
# hs32_mem_arbiter

Two-port memory-bus arbiter that shares the single HS32 external memory bus between the fetch unit (instruction reads) and the execute unit (data loads/stores). Each requester uses a strobe/acknowledge handshake. The arbiter grants one transaction at a time, drives the memory bus from latched request fields, and returns registered read data with a one-cycle acknowledge. A bus watchdog terminates transactions that never receive a memory acknowledge.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles waiting for m_ack before abort; 0 disables the watchdog
- clk  in  1  system clock (12 MHz)
- reset  in  1  asynchronous, active-low reset
- i_stb  in  1  fetch request; held high with i_addr stable until i_ack
- i_addr  in  AW  fetch address
- i_ack  out  1  one-cycle fetch completion pulse
- i_err  out  1  fetch aborted by watchdog; valid with i_ack
- i_dtr  out  DW  fetch read data; valid with i_ack
- d_stb  in  1  data request; held high with d_rw/d_addr/d_dtw stable until d_ack
- d_rw  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_dtw  in  DW  write data
- d_ack  out  1  one-cycle data completion pulse
- d_err  out  1  data access aborted by watchdog; valid with d_ack
- d_dtr  out  DW  read data; valid with d_ack, 0 on writes
- m_stb  out  1  memory bus strobe; high for the whole bus phase
- m_rw  out  1  memory write enable
- m_addr  out  AW  memory address
- m_dtw  out  DW  memory write data
- m_ack  in  1  memory completion; m_dtr valid in the same cycle
- m_dtr  in  DW  memory read data
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - If any strobe is high, select the winner.
  - Latch the winner's rw, addr and dtw. A fetch is always a read.
  - Record the owner and go to BUS.
- BUS:
  - m_stb=1, driven from the latched fields. Requester inputs are ignored.
  - On m_ack: latch m_dtr (or 0 for a write), err=0, go to RESP.
  - If the watchdog expires first: drop m_stb, set dtr=0 and err=1, go to RESP.
- RESP:
  - Pulse the owner's ack for exactly one cycle with its dtr/err; the other port's ack stays 0.
  - Go to IDLE.
- Arbitration, default: fixed priority, data beats fetch. Fetch starvation under continuous data traffic is accepted.
- Any strobe seen in IDLE is a new request. A requester deasserts its strobe or presents a new request in the cycle after its ack.
- Watchdog: counts BUS cycles; expires when the count reaches TIMEOUT. The counter clears on entry to BUS.
- Reset is asynchronous and may hit mid-transaction:
  - All outputs go to 0 immediately: m_stb, m_rw, m_addr, m_dtw, i_ack, d_ack, i_err, d_err, i_dtr, d_dtr, busy.
  - State goes to IDLE and the owner/priority flag clears.
  - The in-flight transaction is dropped; memory must tolerate m_stb falling.

## Timing
- All outputs are registered.
- Request sampled in IDLE at cycle 0. m_stb is high from cycle 1.
- m_ack in cycle k (k≥1) gives the requester's ack in cycle k+1 and IDLE in cycle k+2.
- Minimum request-to-ack latency is 2 cycles; minimum issue interval is 3 cycles per transaction.
- Timeout: m_stb is high for cycles 1..TIMEOUT, the ack with err=1 comes in cycle TIMEOUT+1.
- An m_ack arriving outside BUS is ignored.

## Configuration
- HS32_ARB_RR_EN
  - Defined: round-robin arbitration. On simultaneous strobes in IDLE, grant the port not granted last. A lone strobe is always granted.
  - Undefined: fixed data-over-fetch priority, and no last-grant flag is synthesized.

## Structure
- Shared package hs32_pkg holds:
  - state encodings ST_IDLE/ST_BUS/ST_RESP
  - owner IDs OWN_FETCH/OWN_DATA
- Sub-module hs32_arb_timer holds the watchdog counter: inputs clear/enable, output expired, width derived from TIMEOUT.

## Test plan
- Lone fetch, i_addr=0x100, m_ack one cycle after m_stb with m_dtr=0xDEADBEEF -> m_addr=0x100 with m_rw=0, i_ack in cycle 3 with i_dtr=0xDEADBEEF, busy drops in cycle 4.
- Both strobes in the same cycle, d_rw=1, d_addr=0x200, d_dtw=0x55 -> data served first (m_rw=1, m_dtw=0x55, d_dtr=0), then fetch granted in its following IDLE cycle.
- With HS32_ARB_RR_EN, both strobes held for 4 transactions -> grants alternate data, fetch, data, fetch; without the macro all 4 go to data.
- TIMEOUT=4, m_ack never asserted -> m_stb high for exactly 4 cycles, then ack with err=1 and dtr=0, then IDLE.
- Reset asserted mid-BUS -> m_stb and busy go 0 immediately (asynchronously); after release, a new fetch completes normally.
- Stray m_ack in IDLE -> no ack pulse on either port, state stays IDLE.
